rv32_mem_arbiter: RTL

Two-into-one memory arbiter downstream of the rv32 core: merges the core's instruction port and data port onto a single-port backing memory bus. Grants one transaction at a time, tracks the single outstanding access, and routes the memory response back to the owning port. The data port has priority; an optional starvation guard bounds how long the instruction port can be locked out.

---
 rtl/rv32_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mem_arbiter
// Brief   : Merges the rv32 instruction and data ports onto one single-port
//           memory bus, one outstanding access at a time, data port priority.
//           Optional starvation guard: define RV32_ARB_STARVE_GUARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_request_valid,
    input  logic [31:0] instr_request_addr,
    input  logic        instr_request_write,
    input  logic [3:0]  instr_request_wstrb,
    input  logic [31:0] instr_request_wdata,
    output logic        instr_response_valid,
    output logic [31:0] instr_response_rdata,

    input  logic        data_request_valid,
    input  logic [31:0] data_request_addr,
    input  logic        data_request_write,
    input  logic [3:0]  data_request_wstrb,
    input  logic [31:0] data_request_wdata,
    output logic        data_response_valid,
    output logic [31:0] data_response_rdata,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_idle;
    logic w_force_instr;
    logic w_pick_data;
    logic w_pick_instr;

    // Outputs are combinational, so reset is folded in to hold them at zero
    // for the whole time reset is asserted, not just after the next edge.
    assign w_idle       = (r_state == IDLE) && !reset;
    assign w_pick_data  = w_idle && data_request_valid && !w_force_instr;
    assign w_pick_instr = w_idle && instr_request_valid && !w_pick_data;

`ifdef RV32_ARB_STARVE_GUARD_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_instr = instr_request_valid && (r_starve_cnt >= C_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_pick_instr && mem_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_pick_data && instr_request_valid && (r_starve_cnt != C_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_force_instr = 1'b0;
    assign w_unused_cfg  = (STARVE_LIMIT > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                // A grant in IDLE wins over any stray rvalid arriving alongside it.
                if (w_pick_data && mem_gnt) begin
                    w_state_next = WAIT_D;
                end else if (w_pick_instr && mem_gnt) begin
                    w_state_next = WAIT_I;
                end
            end
            WAIT_I: begin
                if (mem_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        mem_write = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        if (w_pick_data) begin
            mem_req   = 1'b1;
            mem_addr  = data_request_addr;
            mem_write = data_request_write;
            mem_wstrb = data_request_wstrb;
            mem_wdata = data_request_wdata;
        end else if (w_pick_instr) begin
            mem_req   = 1'b1;
            mem_addr  = instr_request_addr;
            mem_write = instr_request_write;
            mem_wstrb = instr_request_wstrb;
            mem_wdata = instr_request_wdata;
        end
    end

    always_comb begin
        instr_response_valid = 1'b0;
        instr_response_rdata = 32'h0;
        data_response_valid  = 1'b0;
        data_response_rdata  = 32'h0;
        if (!reset && mem_rvalid) begin
            if (r_state == WAIT_I) begin
                instr_response_valid = 1'b1;
                instr_response_rdata = mem_rdata;
            end else if (r_state == WAIT_D) begin
                data_response_valid = 1'b1;
                data_response_rdata = mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
